// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Holds the scan state encoding and the segment bit layout.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    // Segment vectors are ordered {g,f,e,d,c,b,a}
    localparam int SEG_W = 7;
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // All segments dark on a common-anode, active-low display
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_scan_ctrl_hex2seven_seg.sv
// Hex nibble to 7-segment decoder.
// The output is active-high, {g,f,e,d,c,b,a}; the caller inverts it for the pins.
module hex2seven_seg
    import seg_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg
);

    // Glyph lookup, including lower-case b and d so they differ from 8 and 0
    always_comb begin
        seg = '0;
        case (hex)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = '0;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. Each digit slot starts with a short blanking gap (selects off,
// segments settling) followed by the lit period. Inputs are snapshotted once
// per frame so a value never tears across digits.
// Optional build macro SEG_SCAN_LEADING_ZERO_BLANK_EN: blank leading zeros.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [SEG_W-1:0]      seven_seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     dig_sel_n,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    scan_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic                 load;
    logic [4*DIGITS-1:0]  snap_digits;
    logic [DIGITS-1:0]    snap_dp;
    logic [3:0]           cur_nib;
    logic                 cur_dp;
    logic [SEG_W-1:0]     dec_seg;
    logic [SEG_W-1:0]     seg_pat;
    logic [DIGITS-1:0]    sel_next;

    // Slot counter, digit index and FSM state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
        end
    end

    // Next-state logic; load marks a frame start (snapshot + frame_tick)
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                    load       = 1'b1;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                    if (cnt == BLANK_LAST) begin
                        state_next = SHOW;
                    end
                end
            end
            SHOW: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else if (cnt == SLOT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    if (idx == IDX_LAST) begin
                        idx_next = '0;
                        load     = 1'b1;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Frame snapshot of the digit values and decimal points
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
        end else if (load) begin
            snap_digits <= digits_in;
            snap_dp     <= dp_in;
        end
    end

    // Select the snapshot nibble and decimal point of the current digit
    always_comb begin
        cur_nib = '0;
        cur_dp  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib = snap_digits[4*k +: 4];
                cur_dp  = snap_dp[k];
            end
        end
    end

    hex2seven_seg u_dec (
        .hex (cur_nib),
        .seg (dec_seg)
    );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] snap_blank;
    logic              zero_above;
    logic              cur_blank;

    // Flag every digit that has only zeros at and above it; digit 0 never blanks
    always_comb begin
        blank_next = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (digits_in[4*k +: 4] == 4'h0);
            blank_next[k] = zero_above;
        end
    end

    // Leading-zero flags are captured together with the digit snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_blank <= '0;
        end else if (load) begin
            snap_blank <= blank_next;
        end
    end

    // A blanked digit stays dark unless its decimal point is requested
    always_comb begin
        cur_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_blank = snap_blank[k];
            end
        end
        seg_pat = (cur_blank && !cur_dp) ? SEG_OFF : ~dec_seg;
    end
`else
    // Every digit is shown, leading zeros included
    always_comb begin
        seg_pat = ~dec_seg;
    end
`endif

    // One-cold digit select for the cycle being entered; only lit in SHOW
    always_comb begin
        sel_next = '1;
        if (state_next == SHOW) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_next == IDX_W'(k)) begin
                    sel_next[k] = 1'b0;
                end
            end
        end
    end

    // Registered pin drivers; segments go dark whenever the scan is idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seven_seg  <= SEG_OFF;
            dp_n       <= 1'b1;
            dig_sel_n  <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= load;
            dig_sel_n  <= sel_next;
            if (state == IDLE || state_next == IDLE) begin
                seven_seg <= SEG_OFF;
                dp_n      <= 1'b1;
            end else begin
                seven_seg <= seg_pat;
                dp_n      <= ~cur_dp;
            end
        end
    end

endmodule
